// File: rtl/sha256_pkg.sv
// ----------------------------------------------------------------------------
// sha256_pkg
//   Shared definitions for the SHA256 message padder:
//     - pad_state_e    : padder FSM state encoding
//     - PAD_BYTE       : the 0x80 terminator byte appended after the message
//     - WORDS_PER_BLK  : 16-bit words per 512-bit block
//     - LEN_WORD_IDX   : block word index where the 64-bit length field starts
//     - LEN_WORDS      : number of 16-bit words in the length field
//     - len_word()     : selects one 16-bit slice of the 64-bit length,
//                        most significant slice first
// ----------------------------------------------------------------------------
package sha256_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        DATA  = 3'd2,
        PAD80 = 3'd3,
        ZERO  = 3'd4,
        LEN   = 3'd5,
        DONE  = 3'd6
    } pad_state_e;

    localparam logic [7:0]          PAD_BYTE      = 8'h80;
    localparam int                  WORDS_PER_BLK = 32;
    localparam int                  IDX_W         = $clog2(WORDS_PER_BLK);
    localparam logic [IDX_W-1:0]    LEN_WORD_IDX  = IDX_W'(28);
    localparam int                  LEN_WORDS     = 4;

    // sel = 0 returns bits [63:48], sel = 3 returns bits [15:0].
    function automatic logic [15:0] len_word(input logic [63:0] bitlen,
                                             input logic [1:0]  sel);
        logic [15:0] w;
        unique case (sel)
            2'd0:    w = bitlen[63:48];
            2'd1:    w = bitlen[47:32];
            2'd2:    w = bitlen[31:16];
            default: w = bitlen[15:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sha256_pad_wordbuf.sv
// ----------------------------------------------------------------------------
// sha256_pad_wordbuf
//   Byte-to-word packer plus the single holding register that presents one
//   16-bit word to the SHA256 core.
//
//   Handshake: o_load is high while a word is held; o_data is stable for the
//   whole time o_load is high. The word is retired on the clock edge where
//   i_ack is sampled high together with o_load. At most one word is ever
//   outstanding; all push inputs are ignored while o_full is high.
//
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     i_clear      : drop any held byte/word (start of a new message)
//     i_byte_push  : push one message byte (first byte becomes the high byte)
//     i_byte       : the byte to push
//     i_word_push  : load a complete 16-bit word (zero fill / length words)
//     i_word       : the word to load
//     i_flush80    : close the message: {held_hi, 8'h80} or 16'h8000
//     i_ack        : core acknowledge
//     o_full       : a word is held and waiting for ack
//     o_load       : core load strobe (same as o_full)
//     o_data       : held word
//     o_retire     : held word is acked this cycle
// ----------------------------------------------------------------------------
module sha256_pad_wordbuf
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_byte_push,
    input  logic [7:0]  i_byte,
    input  logic        i_word_push,
    input  logic [15:0] i_word,
    input  logic        i_flush80,
    input  logic        i_ack,
    output logic        o_full,
    output logic        o_load,
    output logic [15:0] o_data,
    output logic        o_retire
);

    logic [7:0]  r_hi;
    logic        r_hi_valid;
    logic [15:0] r_word;
    logic        r_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi       <= 8'h00;
            r_hi_valid <= 1'b0;
            r_word     <= 16'h0000;
            r_full     <= 1'b0;
        end else if (i_clear) begin
            r_hi_valid <= 1'b0;
            r_full     <= 1'b0;
        end else begin
            if (r_full && i_ack) begin
                r_full <= 1'b0;
            end
            // Pushes only land when nothing is outstanding, so a push and a
            // retire can never collide on the same edge.
            if (i_byte_push && !r_full) begin
                if (r_hi_valid) begin
                    r_word     <= {r_hi, i_byte};
                    r_full     <= 1'b1;
                    r_hi_valid <= 1'b0;
                end else begin
                    r_hi       <= i_byte;
                    r_hi_valid <= 1'b1;
                end
            end else if (i_flush80 && !r_full) begin
                // An odd-length message leaves its last byte waiting for a
                // partner; the terminator fills the low half of that word.
                r_word     <= r_hi_valid ? {r_hi, PAD_BYTE} : {PAD_BYTE, 8'h00};
                r_full     <= 1'b1;
                r_hi_valid <= 1'b0;
            end else if (i_word_push && !r_full) begin
                r_word <= i_word;
                r_full <= 1'b1;
            end
        end
    end

    assign o_full   = r_full;
    assign o_load   = r_full;
    assign o_data   = r_word;
    assign o_retire = r_full && i_ack;

endmodule

// File: rtl/sha256_padder.sv
// ----------------------------------------------------------------------------
// sha256_padder
//   Pads a byte-stream message (0x80 terminator, zero fill, 64-bit big-endian
//   bit length) and feeds it to the SHA256 core as 16-bit words, so the core
//   only ever sees whole 512-bit blocks of 32 words.
//
//   Optional build macro: SHA256_PAD_BLKCNT_EN adds blk_count[15:0], the
//   number of blocks sent for the current message (saturating).
//
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     start       : begin a message (ignored unless idle)
//     in_valid    : in_data holds a byte
//     in_data     : message byte, first byte most significant
//     in_ready    : byte accepted when in_valid & in_ready
//     end_msg     : close the message; a byte accepted with it is included
//     core_init   : one-cycle init pulse to the core
//     core_load   : word valid to the core, held until core_ack
//     core_idata  : word to the core
//     core_ack    : core accepted core_idata
//     busy        : high from start until the last length word is acked
//     msg_done    : one-cycle pulse after the final word is acked
//     dbg_state   : current FSM state (pad_state_e encoding)
//     blk_count   : blocks sent for this message (SHA256_PAD_BLKCNT_EN only)
// ----------------------------------------------------------------------------
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        end_msg,
    output logic        core_init,
    output logic        core_load,
    output logic [15:0] core_idata,
    input  logic        core_ack,
    output logic        busy,
    output logic        msg_done,
    output logic [2:0]  dbg_state
`ifdef SHA256_PAD_BLKCNT_EN
    ,
    output logic [15:0] blk_count
`endif
);

    pad_state_e       r_state;
    logic             r_core_init;
    logic             r_busy;
    logic             r_msg_done;
    logic [LEN_W-1:0] r_len;
    logic [IDX_W-1:0] r_blk_idx;
    logic [2:0]       r_len_cnt;

    logic             w_full;
    logic             w_retire;
    logic             w_clear;
    logic             w_accept;
    logic             w_flush;
    logic             w_zero_push;
    logic             w_len_push;
    logic             w_word_push;
    logic [15:0]      w_word;
    logic [63:0]      w_len64;

    // ------------------------------------------------------------------
    // Datapath control. Every push waits for the holding register to be
    // empty, which keeps exactly one word outstanding to the core.
    // ------------------------------------------------------------------
    assign w_clear     = (r_state == IDLE) && start;
    assign in_ready    = (r_state == DATA) && !w_full;
    assign w_accept    = in_ready && in_valid;
    assign w_flush     = (r_state == PAD80) && !w_full;
    // The index only stops at 28 with nothing outstanding, so a PAD80 word
    // landing at 28..31 naturally runs through the wrap into a fresh block.
    assign w_zero_push = (r_state == ZERO) && !w_full && (r_blk_idx != LEN_WORD_IDX);
    assign w_len_push  = (r_state == LEN) && !w_full && (r_len_cnt != 3'(LEN_WORDS));
    assign w_word_push = w_zero_push || w_len_push;

    always_comb begin
        w_len64              = 64'h0;
        w_len64[LEN_W-1:0]   = r_len;
    end

    always_comb begin
        w_word = 16'h0000;
        if (w_len_push) begin
            w_word = len_word(w_len64, r_len_cnt[1:0]);
        end
    end

    sha256_pad_wordbuf u_wordbuf (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_clear),
        .i_byte_push (w_accept),
        .i_byte      (in_data),
        .i_word_push (w_word_push),
        .i_word      (w_word),
        .i_flush80   (w_flush),
        .i_ack       (core_ack),
        .o_full      (w_full),
        .o_load      (core_load),
        .o_data      (core_idata),
        .o_retire    (w_retire)
    );

    // ------------------------------------------------------------------
    // Padder FSM with registered pulse/level outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_core_init <= 1'b0;
            r_busy      <= 1'b0;
            r_msg_done  <= 1'b0;
            r_len       <= '0;
            r_blk_idx   <= '0;
            r_len_cnt   <= 3'd0;
        end else begin
            r_core_init <= 1'b0;
            r_msg_done  <= 1'b0;

            if (w_retire) begin
                r_blk_idx <= r_blk_idx + IDX_W'(1);
            end
            if (w_accept) begin
                r_len <= r_len + LEN_W'(8);
            end
            if (w_len_push) begin
                r_len_cnt <= r_len_cnt + 3'd1;
            end

            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= INIT;
                        r_core_init <= 1'b1;
                        r_busy      <= 1'b1;
                        r_len       <= '0;
                        r_blk_idx   <= '0;
                        r_len_cnt   <= 3'd0;
                    end
                end
                INIT: begin
                    r_state <= DATA;
                end
                DATA: begin
                    if (end_msg) begin
                        r_state <= PAD80;
                    end
                end
                PAD80: begin
                    if (!w_full) begin
                        r_state <= ZERO;
                    end
                end
                ZERO: begin
                    if (!w_full && (r_blk_idx == LEN_WORD_IDX)) begin
                        r_state <= LEN;
                    end
                end
                LEN: begin
                    // Last length word already loaded; finish on its ack.
                    if (w_retire && (r_len_cnt == 3'(LEN_WORDS))) begin
                        r_state    <= DONE;
                        r_msg_done <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign core_init = r_core_init;
    assign busy      = r_busy;
    assign msg_done  = r_msg_done;
    assign dbg_state = r_state;

`ifdef SHA256_PAD_BLKCNT_EN
    logic [15:0] r_blk_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk_count <= 16'h0000;
        end else if (w_clear) begin
            r_blk_count <= 16'h0000;
        end else if (w_retire && (r_blk_idx == IDX_W'(WORDS_PER_BLK - 1))
                     && (r_blk_count != 16'hFFFF)) begin
            r_blk_count <= r_blk_count + 16'h0001;
        end
    end

    assign blk_count = r_blk_count;
`endif

endmodule

// File: tb/tb_sha256_padder.sv
module tb_sha256_padder;

    // ---------------- clock / reset / DUT ----------------
    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        end_msg;
    logic        core_init;
    logic        core_load;
    logic [15:0] core_idata;
    logic        core_ack;
    logic        busy;
    logic        msg_done;
    logic [2:0]  dbg_state;
`ifdef SHA256_PAD_BLKCNT_EN
    logic [15:0] blk_count;
`endif

    sha256_padder #(.LEN_W(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .end_msg    (end_msg),
        .core_init  (core_init),
        .core_load  (core_load),
        .core_idata (core_idata),
        .core_ack   (core_ack),
        .busy       (busy),
        .msg_done   (msg_done),
        .dbg_state  (dbg_state)
`ifdef SHA256_PAD_BLKCNT_EN
        ,
        .blk_count  (blk_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          n_checks;
    int          n_errors;
    logic [7:0]  msg_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int          ack_delay;
    int          ack_wait;
    int          stab_viol;
    int          ready_viol;
    int          init_cnt;
    int          done_cnt;
    logic [15:0] hold_val;
    bit          hold_valid;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- core model: ack after ack_delay cycles ----------------
    initial begin
        core_ack = 1'b0;
        ack_wait = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                core_ack = 1'b0;
                ack_wait = 0;
            end else if (core_ack) begin
                core_ack = 1'b0;
            end else if (core_load) begin
                if (ack_wait >= ack_delay) begin
                    core_ack = 1'b1;
                    ack_wait = 0;
                end else begin
                    ack_wait++;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (core_init) init_cnt++;
        if (msg_done)  done_cnt++;
        if (core_load && in_ready) ready_viol++;
        if (core_load) begin
            if (hold_valid && (core_idata !== hold_val)) stab_viol++;
            hold_val   = core_idata;
            hold_valid = 1'b1;
            if (core_ack) begin
                got_q.push_back(core_idata);
                hold_valid = 1'b0;
            end
        end else begin
            hold_valid = 1'b0;
        end
    end

    // ---------------- reference model: pad bytes, then pair into words ----------------
    task automatic build_expected();
        logic [7:0]  p[$];
        logic [63:0] bl;
        exp_q.delete();
        p  = msg_q;
        bl = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bl[i*8 +: 8]);
        for (int i = 0; i < p.size(); i += 2) exp_q.push_back({p[i], p[i+1]});
    endtask

    // ---------------- drivers ----------------
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = b;
        end_msg  = 1'b0;
        while (!in_ready && n < 2000) begin
            tick();
            n++;
        end
        check("send_wait", n < 2000, 1);
        end_msg = last;
        tick();
        in_valid = 1'b0;
        end_msg  = 1'b0;
    endtask

    task automatic run_msg(input int delay, input bit inject, input bit gaps);
        int n;
        int init0;
        int done0;
        ack_delay = delay;
        got_q.delete();
        build_expected();
        init0 = init_cnt;
        done0 = done_cnt;
        pulse_start();
        if (msg_q.size() == 0) begin
            n = 0;
            while (!in_ready && n < 100) begin
                tick();
                n++;
            end
            end_msg = 1'b1;
            tick();
            end_msg = 1'b0;
        end else begin
            for (int i = 0; i < msg_q.size(); i++) begin
                if (gaps) repeat ($urandom_range(0, 2)) tick();
                send_byte(msg_q[i], i == msg_q.size() - 1);
                if (inject && i == 0) pulse_start();
            end
        end
        if (inject) begin
            end_msg = 1'b1;
            tick();
            end_msg = 1'b0;
        end
        n = 0;
        while (!msg_done && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("msg_done_wait", n < 6000, 1);
        check("busy_at_done", busy, 0);
        tick();
        check("word_count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("word[%0d]", i), got_q[i], exp_q[i]);
        end
        check("init_pulses", init_cnt - init0, 1);
        check("done_pulses", done_cnt - done0, 1);
`ifdef SHA256_PAD_BLKCNT_EN
        check("blk_count", blk_count, exp_q.size() / 32);
`endif
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          len;
        logic [7:0]  base;
        bit          incr;
        int          delay;
        bit          inject;
        int          exp_words;
        logic [15:0] exp_last;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int sz;
        n_checks = 0; n_errors = 0;
        stab_viol = 0; ready_viol = 0; init_cnt = 0; done_cnt = 0;
        hold_valid = 1'b0; ack_delay = 0;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; end_msg = 1'b0;

        vecs[0] = '{3,  8'h61, 1'b1, 0, 1'b0, 32, 16'h0018};  // "abc"
        vecs[1] = '{0,  8'h00, 1'b0, 0, 1'b0, 32, 16'h0000};  // empty
        vecs[2] = '{56, 8'h00, 1'b0, 0, 1'b0, 64, 16'h01C0};  // spills to 2nd block
        vecs[3] = '{3,  8'h61, 1'b1, 5, 1'b0, 32, 16'h0018};  // slow core
        vecs[4] = '{3,  8'h61, 1'b1, 2, 1'b1, 32, 16'h0018};  // start/end_msg noise
        vecs[5] = '{55, 8'hA0, 1'b1, 1, 1'b0, 32, 16'h01B8};  // exactly fits
        vecs[6] = '{64, 8'h10, 1'b1, 0, 1'b0, 64, 16'h0200};  // full data block
        vecs[7] = '{1,  8'hFF, 1'b0, 0, 1'b0, 32, 16'h0008};  // odd single byte

        // reset state
        repeat (3) tick();
        check("rst_core_init", core_init, 0);
        check("rst_core_load", core_load, 0);
        check("rst_core_idata", core_idata, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_msg_done", msg_done, 0);
        // start coincident with rst: rst wins
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_during_rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        // idle: bytes and end_msg are ignored
        in_valid = 1'b1; in_data = 8'hFF; end_msg = 1'b1;
        tick();
        end_msg = 1'b0;
        repeat (3) tick();
        check("idle_in_ready", in_ready, 0);
        check("idle_busy", busy, 0);
        check("idle_core_load", core_load, 0);
        in_valid = 1'b0;
        tick();

        // table-driven messages
        for (int v = 0; v < 8; v++) begin
            msg_q.delete();
            for (int j = 0; j < vecs[v].len; j++)
                msg_q.push_back(vecs[v].incr ? vecs[v].base + 8'(j) : vecs[v].base);
            run_msg(vecs[v].delay, vecs[v].inject, 1'b0);
            check($sformatf("vec%0d_words", v), got_q.size(), vecs[v].exp_words);
            if (got_q.size() > 0)
                check($sformatf("vec%0d_last", v), got_q[got_q.size()-1], vecs[v].exp_last);
            if (v == 2 && got_q.size() == 64) begin
                check("blk1_pad_word", got_q[28], 16'h8000);
                check("blk2_zero_word", got_q[59], 16'h0000);
            end
            repeat (2) tick();
        end
        check("idata_stable_while_load", stab_viol, 0);
        check("in_ready_low_while_pending", ready_viol, 0);

        // abort mid-message with rst after the 10th word
        msg_q.delete();
        for (int j = 0; j < 100; j++) msg_q.push_back(8'($urandom));
        ack_delay = 0;
        got_q.delete();
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            send_byte(msg_q[i], 1'b0);
            if (got_q.size() >= 10) break;
        end
        check("abort_reached_10_words", got_q.size() >= 10, 1);
        rst = 1'b1;
        tick();
        check("abort_core_load", core_load, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        rst = 1'b0;
        sz = got_q.size();
        repeat (5) tick();
        check("abort_no_more_words", got_q.size(), sz);
        msg_q.delete();
        msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
        run_msg(0, 1'b0, 1'b0);
        check("post_abort_last", got_q[got_q.size()-1], 16'h0018);
        check("post_abort_first", got_q[0], 16'h6162);
        repeat (2) tick();

        // randomized messages against the model
        for (int r = 0; r < 20; r++) begin
            int len;
            len = $urandom_range(0, 130);
            msg_q.delete();
            for (int j = 0; j < len; j++) msg_q.push_back(8'($urandom));
            run_msg($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1);
            repeat ($urandom_range(0, 3)) tick();
        end
        check("final_idata_stable", stab_viol, 0);
        check("final_in_ready_low", ready_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
